bsg_wormhole_concentrator_rr: RTL and testbench



---
 rtl/bsg_wormhole_concentrator_rr.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_bsg_wormhole_concentrator_rr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_concentrator_rr.sv
// N-to-1 wormhole concentrator: per-input FIFOs feeding a packet-granular round-robin arbiter.
// Optional macro BSG_WORMHOLE_CONCENTRATOR_OUT_REG_EN adds a 2-entry flop stage in front of out_*.

module bsg_wormhole_concentrator_rr_chk #(
    parameter int num_in_p = 4
) (
    input logic                clk_i,
    input logic                reset_n_i,
    input logic [num_in_p-1:0] grant_i,
    input logic [num_in_p-1:0] deq_i,
    input logic [num_in_p-1:0] empty_i
);

    grant_onehot_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(grant_i));

    no_deq_empty_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) ((deq_i & empty_i) == '0));

endmodule

module bsg_wormhole_concentrator_rr #(
    parameter int flit_width_p = 16,
    parameter int cord_width_p = 4,
    parameter int len_width_p  = 3,
    parameter int num_in_p     = 4,
    parameter int fifo_els_p   = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_in_p-1:0]              in_v_i,
    input  logic [num_in_p*flit_width_p-1:0] in_data_i,
    output logic [num_in_p-1:0]              in_ready_and_o,
    output logic                             out_v_o,
    output logic [flit_width_p-1:0]          out_data_o,
    input  logic                             out_ready_and_i,
    output logic [num_in_p-1:0]              grant_o
);

    localparam int sel_w_lp = $clog2(num_in_p);
    localparam int ptr_w_lp = $clog2(fifo_els_p);

    typedef enum logic [0:0] {IDLE_S = 1'b0, BUSY_S = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [sel_w_lp-1:0]     owner_q, owner_d;
    logic [sel_w_lp-1:0]     ptr_q, ptr_d;
    logic [sel_w_lp-1:0]     lock_idx_q, lock_idx_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic                    lock_v_q, lock_v_d;
    logic                    ready_en_q, ready_en_d;

    logic [num_in_p-1:0]     head_v_s, enq_s, deq_s, full_s;
    logic [flit_width_p-1:0] head_data_s [num_in_p];
    logic                    rr_found_s;
    logic [sel_w_lp-1:0]     rr_idx_s;
    logic [sel_w_lp:0]       rr_sum_s;
    logic [sel_w_lp-1:0]     sel_s;
    logic                    arb_v_s, arb_ready_s, arb_hs_s;
    logic [flit_width_p-1:0] arb_data_s;
    logic [len_width_p-1:0]  hdr_len_s;
    logic [num_in_p-1:0]     grant_s;

    // Ready stays low until the first edge after reset release.
    assign ready_en_d = 1'b1;

    // Ready-enable register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
        end
    end

    for (genvar k = 0; k < num_in_p; k++) begin : g_fifo
        logic [flit_width_p-1:0] mem_q [fifo_els_p];
        logic [flit_width_p-1:0] mem_d [fifo_els_p];
        logic [ptr_w_lp:0]       wr_q, wr_d, rd_q, rd_d;

        assign head_v_s[k]       = (wr_q != rd_q);
        assign full_s[k]         = (wr_q[ptr_w_lp] != rd_q[ptr_w_lp]) &&
                                   (wr_q[ptr_w_lp-1:0] == rd_q[ptr_w_lp-1:0]);
        assign in_ready_and_o[k] = ready_en_q & ~full_s[k];
        assign enq_s[k]          = in_v_i[k] & in_ready_and_o[k];
        assign deq_s[k]          = arb_hs_s & (sel_s == sel_w_lp'(k));
        assign head_data_s[k]    = mem_q[rd_q[ptr_w_lp-1:0]];

        // FIFO next-state: write at tail, advance pointers on enq/deq.
        always_comb begin
            mem_d = mem_q;
            if (enq_s[k]) begin
                mem_d[wr_q[ptr_w_lp-1:0]] = in_data_i[k*flit_width_p +: flit_width_p];
            end else begin
                mem_d = mem_q;
            end
            wr_d = wr_q + (ptr_w_lp+1)'(enq_s[k]);
            rd_d = rd_q + (ptr_w_lp+1)'(deq_s[k]);
        end

        // FIFO storage and pointer registers.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                mem_q <= '{default: '0};
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                mem_q <= mem_d;
            end
        end
    end

    // First requester at or after the pointer; scanning downward lets the nearest one win.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        rr_sum_s   = '0;
        for (int i = num_in_p - 1; i >= 0; i--) begin
            rr_sum_s = {1'b0, ptr_q} + (sel_w_lp+1)'(i);
            rr_sum_s = (rr_sum_s >= (sel_w_lp+1)'(num_in_p)) ?
                       (rr_sum_s - (sel_w_lp+1)'(num_in_p)) : rr_sum_s;
            if (head_v_s[rr_sum_s[sel_w_lp-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_sum_s[sel_w_lp-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Output decode; a stalled header choice is locked so out_data_o cannot change under stall.
    always_comb begin
        sel_s   = rr_idx_s;
        arb_v_s = 1'b0;
        grant_s = '0;
        case (state_q)
            IDLE_S: begin
                if (lock_v_q) begin
                    sel_s   = lock_idx_q;
                    arb_v_s = 1'b1;
                end else begin
                    sel_s   = rr_idx_s;
                    arb_v_s = rr_found_s;
                end
                grant_s = arb_v_s ? ({{(num_in_p-1){1'b0}}, 1'b1} << sel_s) : '0;
            end
            BUSY_S: begin
                sel_s   = owner_q;
                arb_v_s = head_v_s[owner_q];
                grant_s = {{(num_in_p-1){1'b0}}, 1'b1} << owner_q;
            end
            default: begin
                sel_s   = '0;
                arb_v_s = 1'b0;
                grant_s = '0;
            end
        endcase
    end

    assign arb_data_s = head_data_s[sel_s];
    assign hdr_len_s  = arb_data_s[cord_width_p +: len_width_p];
    assign arb_hs_s   = arb_v_s & arb_ready_s;

    // Next-state: header transfers move the pointer; body transfers count down to IDLE.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        lock_v_d   = lock_v_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            IDLE_S: begin
                if (arb_hs_s) begin
                    ptr_d    = (sel_s == sel_w_lp'(num_in_p - 1)) ? '0 : (sel_s + sel_w_lp'(1));
                    lock_v_d = 1'b0;
                    if (hdr_len_s != '0) begin
                        state_d = BUSY_S;
                        owner_d = sel_s;
                        cnt_d   = hdr_len_s;
                    end else begin
                        state_d = IDLE_S;
                    end
                end else if (arb_v_s) begin
                    lock_v_d   = 1'b1;
                    lock_idx_d = sel_s;
                end else begin
                    lock_v_d = 1'b0;
                end
            end
            BUSY_S: begin
                if (arb_hs_s) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = IDLE_S;
                    end else begin
                        state_d = BUSY_S;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = IDLE_S;
                lock_v_d = 1'b0;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE_S;
            owner_q    <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            lock_v_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            lock_v_q   <= lock_v_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_REG_EN
    logic [flit_width_p-1:0] ob_mem_q [2];
    logic [flit_width_p-1:0] ob_mem_d [2];
    logic                    ob_wr_q, ob_wr_d, ob_rd_q, ob_rd_d;
    logic [1:0]              ob_cnt_q, ob_cnt_d;
    logic                    ob_pop_s;

    assign arb_ready_s = (ob_cnt_q != 2'd2);
    assign ob_pop_s    = (ob_cnt_q != 2'd0) & out_ready_and_i;

    // Output buffer next-state.
    always_comb begin
        ob_mem_d = ob_mem_q;
        if (arb_hs_s) begin
            ob_mem_d[ob_wr_q] = arb_data_s;
        end else begin
            ob_mem_d = ob_mem_q;
        end
        ob_wr_d  = ob_wr_q ^ arb_hs_s;
        ob_rd_d  = ob_rd_q ^ ob_pop_s;
        ob_cnt_d = ob_cnt_q + {1'b0, arb_hs_s} - {1'b0, ob_pop_s};
    end

    // Output buffer registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ob_mem_q <= '{default: '0};
            ob_wr_q  <= 1'b0;
            ob_rd_q  <= 1'b0;
            ob_cnt_q <= 2'd0;
        end else begin
            ob_mem_q <= ob_mem_d;
            ob_wr_q  <= ob_wr_d;
            ob_rd_q  <= ob_rd_d;
            ob_cnt_q <= ob_cnt_d;
        end
    end

    assign out_v_o    = (ob_cnt_q != 2'd0);
    assign out_data_o = ob_mem_q[ob_rd_q];
`else
    assign arb_ready_s = out_ready_and_i;
    assign out_v_o     = arb_v_s;
    assign out_data_o  = arb_data_s;
`endif

    assign grant_o = grant_s;

    bsg_wormhole_concentrator_rr_chk #(
        .num_in_p(num_in_p)
    ) u_chk (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .grant_i  (grant_s),
        .deq_i    (deq_s),
        .empty_i  (~head_v_s)
    );

endmodule

// File: tb/tb_bsg_wormhole_concentrator_rr.sv
// Bench for bsg_wormhole_concentrator_rr: vector table, directed corner sequences, and random traffic
// checked against a queue-level model of the concentrator.

module tb_bsg_wormhole_concentrator_rr;

    localparam int FW = 16;
    localparam int CW = 4;
    localparam int LW = 3;
    localparam int N  = 4;
    localparam int E  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_v;
    logic [N*FW-1:0] in_data;
    logic [N-1:0]    in_rdy;
    logic            out_v;
    logic [FW-1:0]   out_data;
    logic            out_rdy;
    logic [N-1:0]    grant;

    always #5 clk = ~clk;

    bsg_wormhole_concentrator_rr #(
        .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW), .num_in_p(N), .fifo_els_p(E)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .in_v_i(in_v), .in_data_i(in_data),
        .in_ready_and_o(in_rdy), .out_v_o(out_v), .out_data_o(out_data),
        .out_ready_and_i(out_rdy), .grant_o(grant)
    );

    int tests = 0;
    int fails = 0;

    // model: buffered flits per input, sources waiting to be offered, arbitration state
    logic [FW-1:0] mq  [N][$];
    logic [FW-1:0] src [N][$];
    bit m_busy, m_lock, m_rdy_en;
    int m_owner, m_rem, m_ptr, m_lock_idx;

    logic [N-1:0] gate;
    int cyc = 0;
    int out_cnt = 0;
    typedef struct {int cyc; logic [N-1:0] g; logic [FW-1:0] d;} xfer_t;
    xfer_t olog[$];
    logic          s_v;
    logic [N-1:0]  s_g, s_rdy;
    logic [FW-1:0] s_d;

    typedef struct {
        logic [N-1:0]  in_v;
        logic          out_rdy;
        logic          exp_v;
        logic [N-1:0]  exp_g;
        logic [N-1:0]  exp_rdy;
        logic [FW-1:0] exp_d;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [FW-1:0] hdr(int cord, int len, int tag);
        logic [FW-1:0] r;
        r = '0;
        r[CW-1:0]     = cord[CW-1:0];
        r[CW +: LW]   = len[LW-1:0];
        r[FW-1:CW+LW] = tag[FW-CW-LW-1:0];
        return r;
    endfunction

    function automatic int pending();
        int p;
        p = 0;
        for (int k = 0; k < N; k++) p += src[k].size() + mq[k].size();
        return p;
    endfunction

    // One clock cycle: drive, check at negedge against the model, advance the model at posedge.
    task automatic step();
        int sel;
        bit ev;
        logic [N-1:0] eg, erdy, ihs;
        logic [FW-1:0] f;
        int len;
        for (int k = 0; k < N; k++) begin
            in_v[k] = (src[k].size() > 0) && gate[k];
            in_data[k*FW +: FW] = (src[k].size() > 0) ? src[k][0] : '0;
        end
        @(negedge clk);
        sel = 0; ev = 1'b0; eg = '0;
        if (m_busy) begin
            sel = m_owner; ev = (mq[sel].size() > 0);
        end else if (m_lock) begin
            sel = m_lock_idx; ev = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (!ev && mq[j].size() > 0) begin ev = 1'b1; sel = j; end
            end
        end
        if (ev || m_busy) eg = N'(1) << sel;
        for (int k = 0; k < N; k++) erdy[k] = m_rdy_en && (mq[k].size() < E);
        s_v = out_v; s_g = grant; s_rdy = in_rdy; s_d = out_data;
        chk("out_v", out_v, ev);
        chk("grant", grant, eg);
        chk("in_ready", in_rdy, erdy);
        if (ev) chk("out_data", out_data, mq[sel][0]);
        ihs = in_v & erdy;
        @(posedge clk);
        if (ev && out_rdy) begin
            f = mq[sel].pop_front();
            olog.push_back('{cyc, eg, f});
            out_cnt++;
            if (!m_busy) begin
                m_ptr  = (sel + 1) % N;
                m_lock = 1'b0;
                len    = int'(f[CW +: LW]);
                if (len != 0) begin m_busy = 1'b1; m_owner = sel; m_rem = len; end
            end else begin
                m_rem--;
                if (m_rem == 0) m_busy = 1'b0;
            end
        end else if (!m_busy && ev) begin
            m_lock = 1'b1; m_lock_idx = sel;
        end
        for (int k = 0; k < N; k++) if (ihs[k]) mq[k].push_back(src[k].pop_front());
        m_rdy_en = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_v  = 4'b1111;
        for (int k = 0; k < N; k++) begin mq[k].delete(); src[k].delete(); end
        m_busy = 1'b0; m_lock = 1'b0; m_rdy_en = 1'b0; m_ptr = 0; m_rem = 0; m_owner = 0;
        #1;
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_ready", in_rdy, 4'b0000);
        chk("rst_grant", grant, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_out_v", out_v, 1'b0);
        chk("rst_hold_ready", in_rdy, 4'b0000);
        rst_n = 1'b1;
    endtask

    initial begin
        int total_in;
        bit saw_full;
        logic bp [10];
        rst_n = 1'b0; in_v = '0; in_data = '0; out_rdy = 1'b1; gate = '1;

        // Round-robin fairness table, all inputs offering single-flit packets.
        tbl[0] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'h0};
        tbl[1] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 16'h0};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 4'b1111, hdr(0, 0, 0)};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0001, hdr(1, 0, 1)};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 4'b0010, hdr(2, 0, 2)};
        tbl[5] = '{4'b1111, 1'b1, 1'b1, 4'b1000, 4'b0100, hdr(3, 0, 3)};
        tbl[6] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 4'b1000, hdr(0, 0, 0)};
        tbl[7] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0001, hdr(1, 0, 1)};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            gate = tbl[i].in_v; out_rdy = tbl[i].out_rdy;
            for (int k = 0; k < N; k++) while (src[k].size() < 4) src[k].push_back(hdr(k, 0, k));
            step();
            chk("tbl_v", s_v, tbl[i].exp_v);
            chk("tbl_grant", s_g, tbl[i].exp_g);
            chk("tbl_ready", s_rdy, tbl[i].exp_rdy);
            if (tbl[i].exp_v) chk("tbl_data", s_d, tbl[i].exp_d);
        end

        // Wormhole hold: input 2 len=3 packet, input 0 header queued behind it.
        do_reset(); gate = '1; out_rdy = 1'b1;
        step();
        src[2].push_back(hdr(2, 3, 5));
        src[2].push_back(16'h1111); src[2].push_back(16'h2222); src[2].push_back(16'h3333);
        step();
        src[0].push_back(hdr(0, 0, 6));
        olog.delete();
        for (int i = 0; i < 8; i++) step();
        chk("wh_count", olog.size(), 5);
        if (olog.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("wh_grant", olog[i].g, 4'b0100);
                chk("wh_contig", olog[i].cyc, olog[0].cyc + i);
            end
            chk("wh_body3", olog[3].d, 16'h3333);
            chk("wh_next_grant", olog[4].g, 4'b0001);
            chk("wh_next_data", olog[4].d, hdr(0, 0, 6));
            chk("wh_next_contig", olog[4].cyc, olog[0].cyc + 4);
        end

        // Backpressure during a len=2 packet.
        do_reset(); gate = '1;
        bp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        src[1].push_back(hdr(1, 2, 7)); src[1].push_back(16'hB001); src[1].push_back(16'hB002);
        src[1].push_back(hdr(1, 0, 8)); src[1].push_back(hdr(1, 0, 9));
        olog.delete(); saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_rdy = bp[i];
            step();
            if (!bp[i] && !s_rdy[1]) saw_full = 1'b1;
        end
        chk("bp_ready_drop", saw_full, 1'b1);
        chk("bp_count", olog.size(), 5);
        if (olog.size() >= 5) begin
            chk("bp_d1", olog[1].d, 16'hB001);
            chk("bp_d2", olog[2].d, 16'hB002);
            chk("bp_d4", olog[4].d, hdr(1, 0, 9));
        end

        // Upstream gap inside input 1's packet, input 3 waiting.
        do_reset(); gate = '1; out_rdy = 1'b1;
        step();
        src[1].push_back(hdr(1, 2, 10)); src[3].push_back(hdr(3, 0, 11));
        olog.delete();
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gap_grant", s_g, 4'b0010);
            chk("gap_v", s_v, 1'b0);
        end
        src[1].push_back(16'hC001); src[1].push_back(16'hC002);
        for (int i = 0; i < 6; i++) step();
        chk("gap_count", olog.size(), 4);
        if (olog.size() >= 4) begin
            chk("gap_b2_grant", olog[2].g, 4'b0010);
            chk("gap_b2_data", olog[2].d, 16'hC002);
            chk("gap_in3_grant", olog[3].g, 4'b1000);
            chk("gap_in3_data", olog[3].d, hdr(3, 0, 11));
        end

        // Reset after 2 of 5 flits; pointer and buffers must start clean.
        do_reset(); gate = '1; out_rdy = 1'b1;
        src[2].push_back(hdr(2, 4, 12));
        for (int i = 1; i <= 4; i++) src[2].push_back(16'hD000 + 16'(i));
        olog.delete();
        for (int i = 0; i < 10 && olog.size() < 2; i++) step();
        chk("mid_two_out", olog.size(), 2);
        do_reset(); gate = '1;
        src[0].push_back(hdr(0, 0, 13)); src[3].push_back(hdr(3, 0, 14));
        olog.delete();
        for (int i = 0; i < 6; i++) step();
        chk("mid_count", olog.size(), 2);
        if (olog.size() >= 2) begin
            chk("mid_first_grant", olog[0].g, 4'b0001);
            chk("mid_first_data", olog[0].d, hdr(0, 0, 13));
            chk("mid_second_data", olog[1].d, hdr(3, 0, 14));
        end

        // Random traffic against the model.
        do_reset();
        out_cnt = 0; total_in = 0;
        for (int c = 0; c < 3000; c++) begin
            gate    = N'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (src[k].size() < 3 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 2));
                    src[k].push_back(hdr(k, len, int'($urandom_range(0, 511))));
                    for (int b = 0; b < len; b++) src[k].push_back(FW'($urandom));
                    total_in += 1 + len;
                end
            end
            step();
        end
        gate = '1; out_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (pending() == 0) break;
            step();
        end
        chk("rand_drained", pending(), 0);
        chk("rand_flit_count", out_cnt, total_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
